dense_layer_ctrl: RTL and testbench
===================================

Name: dense_layer_ctrl

Overview:
Sequences one external 16x16 Q4.12 multiply-accumulate unit through a fully-connected layer of the MNIST accelerator. For each output neuron it clears the accumulator, generates input and weight read addresses, and aligns the MAC valid strobe with memory read latency. It then adds the neuron bias, saturates the result to 16 bits, and writes it to the output buffer. Sits between the layer sequencer (start/done) and the input, weight and bias memories, the MAC unit and the output memory.

Parameters:
IN_LEN, 784, inputs per neuron (>=1)
OUT_LEN, 10, neurons in layer (>=1)
DW, 16, data width of x, w, bias, y (signed Q4.12)
ACC_W, 40, MAC accumulator width
RD_LAT, 1, read latency of the x, w and bias memories in cycles (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin layer; accepted only in IDLE
abort  in  1  synchronous abort; return to IDLE, no done
busy  out  1  high from start accept until done cycle inclusive
done  out  1  one-cycle pulse, layer complete
rd_en  out  1  read strobe to x and w memories
x_addr  out  $clog2(IN_LEN)  input index
w_addr  out  $clog2(IN_LEN*OUT_LEN)  weight index = neuron*IN_LEN + i
b_addr  out  $clog2(OUT_LEN)  current neuron index
bias  in  DW  bias data, valid RD_LAT cycles after b_addr changes
mac_valid_in  out  1  to MAC valid_in
mac_clr_acc  out  1  to MAC clr_acc
mac_dout  in  ACC_W  MAC accumulator
y_we  out  1  output write strobe
y_addr  out  $clog2(OUT_LEN)  output index
y_data  out  DW  saturated result

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; every output 0; counters 0; delay line cleared. Reset dominates abort and start.
- FSM: IDLE -> CLR on start. CLR (1 cycle, mac_clr_acc=1) -> STREAM. STREAM (IN_LEN cycles, rd_en=1, i=0..IN_LEN-1) -> DRAIN. DRAIN (RD_LAT+1 cycles) -> WRITE. WRITE (1 cycle, y_we=1) -> CLR if neuron<OUT_LEN-1, else DONE. DONE (1 cycle, done=1) -> IDLE.
- mac_valid_in = rd_en delayed by exactly RD_LAT cycles through a shift register. DRAIN covers the last valid plus one MAC register stage, so mac_dout is final in WRITE.
- w_addr is a running counter incremented per read and never reset between neurons; no multiplier. x_addr wraps to 0 at each CLR.
- b_addr = y_addr = neuron, stable for the whole neuron; bias is sampled in WRITE.
- WRITE arithmetic: s = mac_dout + sign-extend(bias) at ACC_W+1 bits; y_data = 32767 if s>32767, -32768 if s<-32768, else s[DW-1:0].
- Per-neuron cycles = IN_LEN+RD_LAT+3. done asserts exactly OUT_LEN*(IN_LEN+RD_LAT+3)+1 cycles after the start-accept edge.
- start while busy: ignored. start and abort in the same cycle in IDLE: abort wins, stay IDLE.
- abort in any state: next cycle IDLE, rd_en=0, delay line flushed, no y_we, no done. Output memory contents already written are kept.
- rd_en, mac_valid_in, y_we, done and mac_clr_acc are 0 outside their states.

Optional Feature:
DENSE_RELU_EN: when defined, y_data = 0 if the saturated result is negative (ReLU applied after saturation). When undefined, the signed saturated value is written unchanged. Timing is identical in both builds.

Decomposition:
- Package mnist_pkg: DW, ACC_W, FRAC=12 constants; typedef enum for the FSM states (IDLE, CLR, STREAM, DRAIN, WRITE, DONE); function sat_to_dw.
- One sub-module: valid_delay_line (parameter DEPTH=RD_LAT, synchronous clear on rst or abort) producing mac_valid_in from rd_en.

Test Plan:
- IN_LEN=4, OUT_LEN=2, RD_LAT=1; all x=4096, all w=2048, bias=4096 -> y[0]=y[1]=12288; done exactly 17 cycles after start accept.
- All x=w=32767, bias=0 -> each product 262128, sum 1048512 -> y=32767. All x=32767, w=-32768 -> y=-32768.
- x=4096, w=-4096, bias=0 -> s=-16384. With DENSE_RELU_EN: y=0. Without it: y=-16384.
- Assert abort in the STREAM cycle of neuron 1 -> IDLE next cycle, no y_we[1], no done. A fresh start then completes normally with correct values.
- Pulse start every cycle while busy -> exactly one done, exactly OUT_LEN y_we pulses. Check w_addr sequence 0..7 contiguous across neurons.
- RD_LAT=3 -> mac_valid_in lags rd_en by exactly 3 cycles, results are unchanged, and done arrives at 2*(4+6)+1=21 cycles.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared types and helpers for the MNIST accelerator datapath blocks.
// Provides Q4.12 width constants, the dense-layer FSM state type and saturation.
package mnist_pkg;

  localparam int DW    = 16;
  localparam int ACC_W = 40;
  localparam int FRAC  = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_t;

  // In range when every bit above the DW-bit result matches the sign bit.
  function automatic logic signed [DW-1:0] sat_to_dw(input logic signed [ACC_W:0] s);
    logic signed [DW-1:0] r;
    if (s[ACC_W:DW-1] == {(ACC_W-DW+2){s[ACC_W]}})
      r = s[DW-1:0];
    else if (s[ACC_W])
      r = {1'b1, {(DW-1){1'b0}}};
    else
      r = {1'b0, {(DW-1){1'b1}}};
    return r;
  endfunction

endpackage

// File: rtl/dense_layer_ctrl_valid_delay_line.sv
// Delays the memory read strobe so the MAC valid lines up with read data.
// Cleared synchronously on reset or abort so no stale valid reaches the MAC.
module valid_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic abort,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] vld_p0;

  always_ff @(posedge clk) begin
    if (rst || abort)
      vld_p0 <= '0;
    else
      vld_p0 <= (vld_p0 << 1) | DEPTH'(din);
  end

  assign dout = vld_p0[DEPTH-1];

endmodule

// File: rtl/dense_layer_ctrl.sv
// Fully-connected layer sequencer driving one external Q4.12 MAC unit.
// Optional macro DENSE_RELU_EN clamps negative saturated outputs to zero.
module dense_layer_ctrl #(
  parameter int IN_LEN  = 784,
  parameter int OUT_LEN = 10,
  parameter int DW      = 16,
  parameter int ACC_W   = 40,
  parameter int RD_LAT  = 1,
  localparam int XW = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
  localparam int WW = (IN_LEN * OUT_LEN > 1) ? $clog2(IN_LEN * OUT_LEN) : 1,
  localparam int NW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [XW-1:0]    x_addr,
  output logic [WW-1:0]    w_addr,
  output logic [NW-1:0]    b_addr,
  input  logic [DW-1:0]    bias,
  output logic             mac_valid_in,
  output logic             mac_clr_acc,
  input  logic [ACC_W-1:0] mac_dout,
  output logic             y_we,
  output logic [NW-1:0]    y_addr,
  output logic [DW-1:0]    y_data
);

  import mnist_pkg::*;

  localparam int DCW = $clog2(RD_LAT + 2);

  state_t          state, nxt;
  logic [DCW-1:0]  drain_cnt;
  logic [NW-1:0]   neuron;
  logic            x_last, drain_last, neuron_last;

  logic signed [ACC_W:0]  sum_s;
  logic signed [DW-1:0]   sat_s;
  logic signed [DW-1:0]   res_s;

  assign x_last      = (x_addr == XW'(IN_LEN - 1));
  assign drain_last  = (drain_cnt == DCW'(RD_LAT));
  assign neuron_last = (neuron == NW'(OUT_LEN - 1));

  assign b_addr = neuron;
  assign y_addr = neuron;

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt         = state;
    busy        = 1'b0;
    rd_en       = 1'b0;
    mac_clr_acc = 1'b0;
    y_we        = 1'b0;
    done        = 1'b0;
    y_data      = '0;
    case (state)
      IDLE: begin
        if (start)
          nxt = CLR;
      end
      CLR: begin
        busy        = 1'b1;
        mac_clr_acc = 1'b1;
        nxt         = STREAM;
      end
      STREAM: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (x_last)
          nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_last)
          nxt = WRITE;
      end
      WRITE: begin
        busy   = 1'b1;
        y_we   = 1'b1;
        y_data = res_s;
        nxt    = neuron_last ? DONE : CLR;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
    if (abort)
      nxt = IDLE;
  end

  // w_addr runs across neurons so no neuron*IN_LEN product is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_addr    <= '0;
      w_addr    <= '0;
      neuron    <= '0;
      drain_cnt <= '0;
    end else if (!abort) begin
      case (state)
        IDLE: begin
          if (start) begin
            x_addr <= '0;
            w_addr <= '0;
            neuron <= '0;
          end
        end
        CLR: begin
          x_addr    <= '0;
          drain_cnt <= '0;
        end
        STREAM: begin
          w_addr <= w_addr + WW'(1);
          x_addr <= x_last ? '0 : x_addr + XW'(1);
        end
        DRAIN: drain_cnt <= drain_cnt + DCW'(1);
        WRITE: begin
          if (!neuron_last)
            neuron <= neuron + NW'(1);
        end
        default: ;
      endcase
    end
  end

  valid_delay_line #(
    .DEPTH (RD_LAT)
  ) u_vld_dly (
    .clk   (clk),
    .rst   (rst),
    .abort (abort),
    .din   (rd_en),
    .dout  (mac_valid_in)
  );

  // Bias add one bit wider than the accumulator so the sum cannot wrap.
  assign sum_s = $signed({mac_dout[ACC_W-1], mac_dout})
               + $signed({{(ACC_W + 1 - DW){bias[DW-1]}}, bias});
  assign sat_s = sat_to_dw(sum_s);

`ifdef DENSE_RELU_EN
  assign res_s = sat_s[DW-1] ? '0 : sat_s;
`else
  assign res_s = sat_s;
`endif

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// Self-checking bench: two controllers (read latency 1 and 3) share memories and stimulus.
// A cycle-schedule model derived from the layer timing rules checks every output each cycle.
module tb_dense_layer_ctrl;

  localparam int IN_LEN  = 4;
  localparam int OUT_LEN = 2;
  localparam int DW      = 16;
  localparam int ACC_W   = 40;
  localparam int XW      = 2;
  localparam int WW      = 3;
  localparam int NW      = 1;
  localparam int NI      = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort;

  logic signed [15:0] x_mem [IN_LEN];
  logic signed [15:0] w_mem [IN_LEN*OUT_LEN];
  logic signed [15:0] b_mem [OUT_LEN];

  logic             busy_o [NI];
  logic             done_o [NI];
  logic             rd_o   [NI];
  logic             mv_o   [NI];
  logic             clr_o  [NI];
  logic             we_o   [NI];
  logic [XW-1:0]    xa_o   [NI];
  logic [WW-1:0]    wa_o   [NI];
  logic [NW-1:0]    ba_o   [NI];
  logic [NW-1:0]    ya_o   [NI];
  logic [DW-1:0]    yd_o   [NI];
  logic [DW-1:0]    bias_i [NI];
  logic [ACC_W-1:0] acc_i  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [XW-1:0] xa_p [LAT];
    logic [WW-1:0] wa_p [LAT];
    logic [NW-1:0] ba_p [LAT];
    logic signed [15:0] xd, wd;
    logic signed [ACC_W-1:0] prod, acc;
    logic pv;

    // Memories with LAT cycles of read latency.
    always @(posedge clk) begin
      xa_p[0] <= xa_o[g];
      wa_p[0] <= wa_o[g];
      ba_p[0] <= ba_o[g];
      for (int j = 1; j < LAT; j++) begin
        xa_p[j] <= xa_p[j-1];
        wa_p[j] <= wa_p[j-1];
        ba_p[j] <= ba_p[j-1];
      end
    end
    assign xd        = x_mem[xa_p[LAT-1]];
    assign wd        = w_mem[wa_p[LAT-1]];
    assign bias_i[g] = b_mem[ba_p[LAT-1]];

    // MAC: registered rounded Q4.12 product, then accumulator.
    always @(posedge clk) begin
      if (clr_o[g]) begin
        acc <= '0;
        pv  <= 1'b0;
      end else begin
        prod <= ACC_W'((longint'(xd) * longint'(wd) + 64'sd2048) >>> 12);
        pv   <= mv_o[g];
        if (pv)
          acc <= acc + prod;
      end
    end
    assign acc_i[g] = acc;

    dense_layer_ctrl #(
      .IN_LEN  (IN_LEN),
      .OUT_LEN (OUT_LEN),
      .DW      (DW),
      .ACC_W   (ACC_W),
      .RD_LAT  (LAT)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .busy         (busy_o[g]),
      .done         (done_o[g]),
      .rd_en        (rd_o[g]),
      .x_addr       (xa_o[g]),
      .w_addr       (wa_o[g]),
      .b_addr       (ba_o[g]),
      .bias         (bias_i[g]),
      .mac_valid_in (mv_o[g]),
      .mac_clr_acc  (clr_o[g]),
      .mac_dout     (acc_i[g]),
      .y_we         (we_o[g]),
      .y_addr       (ya_o[g]),
      .y_data       (yd_o[g])
    );
  end

  // Behavioural model state: active flag and cycle index since start accept.
  bit          act [NI];
  int          kk [NI];
  bit          hist [NI][4];
  int          acc_cyc [NI], done_cyc [NI], done_cnt [NI], we_cnt [NI], rd_cnt [NI];
  logic [15:0] ymem [NI][OUT_LEN];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  function automatic int lat(int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int per(int g);
    return IN_LEN + lat(g) + 3;
  endfunction

  function automatic longint exp_y(int n);
    longint s;
    s = longint'(b_mem[n]);
    for (int i = 0; i < IN_LEN; i++)
      s += (longint'(x_mem[i]) * longint'(w_mem[n*IN_LEN + i]) + 2048) >>> 12;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`ifdef DENSE_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  function automatic bit exp_rd(int g);
    int ph;
    if (!act[g] || kk[g] > OUT_LEN * per(g)) return 1'b0;
    ph = (kk[g] - 1) % per(g);
    return (ph >= 1) && (ph <= IN_LEN);
  endfunction

  task automatic chk(int g, string nm, longint got, longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s[%0d] cycle %0d: got %0d, expected %0d", nm, g, cyc, got, want);
    end
  endtask

  task automatic check_cycle();
    for (int g = 0; g < NI; g++) begin
      int  p, ph, n;
      bit  inl;
      p   = per(g);
      ph  = (kk[g] - 1) % p;
      n   = (kk[g] - 1) / p;
      inl = act[g] && (kk[g] <= OUT_LEN * p);
      chk(g, "busy", busy_o[g], act[g]);
      chk(g, "done", done_o[g], act[g] && (kk[g] == OUT_LEN * p + 1));
      chk(g, "mac_clr_acc", clr_o[g], inl && (ph == 0));
      chk(g, "rd_en", rd_o[g], exp_rd(g));
      chk(g, "y_we", we_o[g], inl && (ph == p - 1));
      chk(g, "mac_valid_in", mv_o[g], hist[g][lat(g)-1]);
      if (exp_rd(g)) begin
        chk(g, "x_addr", xa_o[g], ph - 1);
        chk(g, "w_addr", wa_o[g], n * IN_LEN + ph - 1);
      end
      if (inl) begin
        chk(g, "b_addr", ba_o[g], n);
        chk(g, "y_addr", ya_o[g], n);
      end
      if (inl && (ph == p - 1))
        chk(g, "y_data", longint'($signed(yd_o[g])), exp_y(n));
      if (we_o[g]) begin
        ymem[g][ya_o[g]] = yd_o[g];
        we_cnt[g]++;
      end
      if (done_o[g]) begin
        done_cnt[g]++;
        done_cyc[g] = cyc;
      end
      if (rd_o[g]) rd_cnt[g]++;
    end
  endtask

  task automatic step();
    bit erd [NI];
    for (int g = 0; g < NI; g++) erd[g] = exp_rd(g);
    @(posedge clk);
    for (int g = 0; g < NI; g++) begin
      if (rst || abort) begin
        act[g] = 1'b0;
        for (int j = 0; j < 4; j++) hist[g][j] = 1'b0;
      end else begin
        for (int j = 3; j > 0; j--) hist[g][j] = hist[g][j-1];
        hist[g][0] = erd[g];
        if (act[g]) begin
          if (kk[g] == OUT_LEN * per(g) + 1) act[g] = 1'b0;
          else kk[g]++;
        end else if (start) begin
          act[g]     = 1'b1;
          kk[g]      = 1;
          acc_cyc[g] = cyc + 1;
        end
      end
    end
    cyc++;
    #1;
    check_cycle();
  endtask

  task automatic clear_stats();
    for (int g = 0; g < NI; g++) begin
      done_cnt[g] = 0;
      we_cnt[g]   = 0;
      rd_cnt[g]   = 0;
      done_cyc[g] = 0;
      for (int n = 0; n < OUT_LEN; n++) ymem[g][n] = 16'h5a5a;
    end
  endtask

  task automatic fill(int xv, int wv, int bv);
    for (int i = 0; i < IN_LEN; i++) x_mem[i] = 16'(xv);
    for (int i = 0; i < IN_LEN * OUT_LEN; i++) w_mem[i] = 16'(wv);
    for (int i = 0; i < OUT_LEN; i++) b_mem[i] = 16'(bv);
  endtask

  task automatic fill_rand();
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < IN_LEN; i++)
      x_mem[i] = (mode == 0) ? 16'($urandom) : 16'($urandom_range(0, 8191) - 4096);
    for (int i = 0; i < IN_LEN * OUT_LEN; i++)
      w_mem[i] = (mode == 2) ? 16'($urandom_range(0, 4095)) : 16'($urandom);
    for (int i = 0; i < OUT_LEN; i++)
      b_mem[i] = 16'($urandom_range(0, 16383) - 8192);
  endtask

  task automatic run_layer();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t < 200 && (act[0] || act[1]); t++) step();
    chk(0, "layer_timeout", longint'(act[0] | act[1]), 0);
  endtask

  int exp_lat [NI] = '{17, 21};

  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    fill(0, 0, 0);
    clear_stats();
    for (int i = 0; i < 3; i++) step();
    for (int g = 0; g < NI; g++) begin
      chk(g, "rst_x_addr", xa_o[g], 0);
      chk(g, "rst_w_addr", wa_o[g], 0);
      chk(g, "rst_b_addr", ba_o[g], 0);
      chk(g, "rst_y_data", yd_o[g], 0);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    step();

    // Unity-scaled layer with bias.
    fill(4096, 2048, 4096);
    clear_stats();
    run_layer();
    for (int g = 0; g < NI; g++) begin
      chk(g, "done_latency", done_cyc[g] - acc_cyc[g] + 1, exp_lat[g]);
      chk(g, "y0_unity", longint'($signed(ymem[g][0])), 12288);
      chk(g, "y1_unity", longint'($signed(ymem[g][1])), 12288);
      chk(g, "done_count", done_cnt[g], 1);
    end

    fill(32767, 32767, 0);
    clear_stats();
    run_layer();
    for (int g = 0; g < NI; g++)
      chk(g, "y_sat_pos", longint'($signed(ymem[g][1])), 32767);

    fill(32767, -32768, 0);
    clear_stats();
    run_layer();
    for (int g = 0; g < NI; g++)
      chk(g, "y_sat_neg", longint'($signed(ymem[g][0])), -32768);

    fill(4096, -4096, 0);
    clear_stats();
    run_layer();
    for (int g = 0; g < NI; g++)
`ifdef DENSE_RELU_EN
      chk(g, "y_neg", longint'($signed(ymem[g][0])), 0);
`else
      chk(g, "y_neg", longint'($signed(ymem[g][0])), -16384);
`endif

    for (int r = 0; r < 8; r++) begin
      fill_rand();
      clear_stats();
      run_layer();
      for (int g = 0; g < NI; g++) chk(g, "rand_we_count", we_cnt[g], OUT_LEN);
    end

    // Abort during neuron 1 streaming (cycle 12 after accept for both latencies).
    fill_rand();
    clear_stats();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 11; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int i = 0; i < 6; i++) step();
    for (int g = 0; g < NI; g++) begin
      chk(g, "abort_we_count", we_cnt[g], 1);
      chk(g, "abort_done_count", done_cnt[g], 0);
      chk(g, "abort_busy", busy_o[g], 0);
    end
    fill_rand();
    clear_stats();
    run_layer();
    for (int g = 0; g < NI; g++) begin
      chk(g, "post_abort_done", done_cnt[g], 1);
      chk(g, "post_abort_we", we_cnt[g], OUT_LEN);
    end

    // Start held high while busy must not restart the layer.
    fill_rand();
    clear_stats();
    start = 1'b1;
    step();
    for (int t = 0; t < 100 && act[0] && kk[0] < OUT_LEN * per(0) + 1; t++) step();
    start = 1'b0;
    for (int t = 0; t < 100 && (act[0] || act[1]); t++) step();
    for (int g = 0; g < NI; g++) begin
      chk(g, "held_start_done", done_cnt[g], 1);
      chk(g, "held_start_we", we_cnt[g], OUT_LEN);
      chk(g, "held_start_reads", rd_cnt[g], IN_LEN * OUT_LEN);
    end

    // Start and abort together in idle: abort wins.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    step();
    for (int g = 0; g < NI; g++) chk(g, "start_abort_idle", busy_o[g], 0);

    // Reset mid-layer dominates a concurrent start.
    clear_stats();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    step();
    for (int g = 0; g < NI; g++) begin
      chk(g, "rst_mid_busy", busy_o[g], 0);
      chk(g, "rst_mid_done", done_cnt[g], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
